// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: packs variable-length LSB-first code words into a byte stream,
// with a flush that zero-pads and tags the final byte.
module huffman_bit_packer #(
    parameter int MAX_LEN = 15,
    parameter int ACC_W   = 32,
    parameter int LEN_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_LEN-1:0] in_code,
    input  logic [LEN_W-1:0]   in_len,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic               out_last,
    output logic               flush_done,
    output logic [31:0]        bits_total
);
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [1:0] RUN = 2'd0, FLUSH = 2'd1, DONE = 2'd2;

    logic [1:0]       state, state_n;
    logic [ACC_W-1:0] acc, acc_n, code_m;
    logic [CNT_W-1:0] cnt, cnt_n, used;
    logic [LEN_W-1:0] len_c;
    logic             accept, emit;

    assign in_ready   = state == RUN && cnt <= CNT_W'(ACC_W - MAX_LEN);
    assign out_valid  = cnt >= CNT_W'(8) || (state == FLUSH && cnt != '0);
    assign out_last   = state == FLUSH && cnt != '0 && cnt <= CNT_W'(8);
    assign out_byte   = acc[7:0];
    assign flush_done = state == DONE;
    assign accept     = in_valid && in_ready;
    assign emit       = out_valid && out_ready;

    // Masking keeps bits above cnt at zero, which is what makes flush padding zero.
    always_comb begin
        len_c   = in_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : in_len;
        code_m  = ACC_W'(in_code) & ~({ACC_W{1'b1}} << len_c);
        used    = emit ? (cnt < CNT_W'(8) ? cnt : CNT_W'(8)) : '0;
        acc_n   = (emit ? acc >> 8 : acc) | (accept ? code_m << (cnt - used) : '0);
        cnt_n   = cnt - used + (accept ? CNT_W'(len_c) : '0);
        state_n = state == RUN   ? (flush ? FLUSH : RUN) :
                  state == FLUSH ? ((cnt == '0 || (emit && out_last)) ? DONE : FLUSH) :
                  RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            cnt        <= '0;
            state      <= RUN;
            bits_total <= '0;
        end else begin
            acc        <= acc_n;
            cnt        <= cnt_n;
            state      <= state_n;
            bits_total <= accept ? bits_total + 32'(len_c) : bits_total;
        end
    end
endmodule
